flash_wb_arbiter: RTL and testbench
===================================

Name: flash_wb_arbiter

Overview:
- Two-master Wishbone classic arbiter that shares the single `flash_controller` slave port between requesters, e.g. the instruction-fetch port (M0) and the data/readback port (M1).
- Grants one master at a time using round-robin priority.
- Forwards the granted master's cycle to the flash controller and routes ack, retry and read data back to that master only.
- A watchdog aborts transfers the flash controller never completes.

Parameters:
TIMEOUT, 4096, cycles a granted transfer may stay open before being aborted with error (min 2)
TW, 13, width of the watchdog counter; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_m0_adr  in  32  master 0 address
i_m0_dat  in  32  master 0 write data
i_m0_sel  in  4  master 0 byte select
i_m0_we  in  1  master 0 write enable
i_m0_cyc  in  1  master 0 cycle
i_m0_stb  in  1  master 0 strobe
o_m0_rdt  out  32  master 0 read data
o_m0_ack  out  1  master 0 ack
o_m0_rty  out  1  master 0 retry
o_m0_err  out  1  master 0 error (watchdog abort)
i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc, i_m1_stb, o_m1_rdt, o_m1_ack, o_m1_rty, o_m1_err: same as M0, for master 1
o_s_adr  out  32  to flash_controller i_wb_adr
o_s_dat  out  32  to flash_controller i_wb_dat
o_s_sel  out  4  to flash_controller i_wb_sel
o_s_we  out  1  to flash_controller i_wb_we
o_s_cyc  out  1  to flash_controller i_wb_cyc
o_s_stb  out  1  to flash_controller i_wb_stb
i_s_rdt  in  32  from flash_controller o_wb_rdt
i_s_ack  in  1  from flash_controller o_wb_ack
i_s_rty  in  1  from flash_controller o_wb_rty
o_gnt  out  2  one-hot current grant (debug/status)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = S_IDLE, grant = 0, priority pointer = M0, watchdog = 0.
  - All o_s_* and o_m*_ack/rty/err = 0; o_m*_rdt = 0; o_gnt = 2'b00.
- Request definition: req_k = i_mk_cyc & i_mk_stb.
- State machine (states S_IDLE, S_XFER, S_ERR):
  - S_IDLE, no req: stay.
  - S_IDLE, one req: latch that grant, go to S_XFER.
  - S_IDLE, both req: grant the master named by the priority pointer, go to S_XFER.
  - S_XFER: o_s_adr/dat/sel/we are a combinational mux of the granted master's inputs. o_s_cyc/o_s_stb = granted master's cyc & stb.
  - S_XFER, i_s_ack: o_mk_ack = 1 to the granted master in the same cycle, and o_mk_rdt = i_s_rdt. Next: S_IDLE; priority pointer moves to the other master.
  - S_XFER, i_s_rty (without ack): o_mk_rty = 1 in the same cycle. Next: S_IDLE; priority pointer moves to the other master.
  - Ack and rty both high: ack wins, rty suppressed.
  - S_XFER, granted master drops cyc before ack: o_s_cyc/stb fall in the same cycle; next S_IDLE; no ack/err issued; pointer unchanged.
  - S_XFER, watchdog reaches TIMEOUT-1 with no ack/rty: next S_ERR.
  - S_ERR, 1 cycle: o_s_cyc/stb = 0 (aborts the flash controller); o_mk_err = 1 to the granted master; next S_IDLE; pointer moves to the other master.
- Watchdog: clears on entry to S_XFER; increments each S_XFER cycle; saturates; held at 0 outside S_XFER.
- The non-granted master always sees ack/rty/err = 0 and rdt = 0. A late slave ack arriving in S_IDLE or S_ERR is dropped.
- o_m*_rdt is zero except in the acked cycle, and is not registered.
- Latency: request seen in S_IDLE at edge N → o_s_cyc/stb high from cycle N+1. Master ack occurs in the same cycle as the slave ack. Minimum one S_IDLE cycle between grants, so back-to-back transfers from alternating masters cost 1 idle cycle each.
- o_gnt = one-hot grant while in S_XFER/S_ERR, else 00.
- The arbiter holds no pending-request memory. Masters hold cyc/stb until ack/rty/err (Wishbone classic).

Test Plan:
1. M0-only read: M0 cyc/stb, slave acks after 5 cycles with rdt=32'hDEADBEEF → o_s_cyc rises 1 cycle after request; o_m0_ack=1 and o_m0_rdt=DEADBEEF in the ack cycle; o_m1_ack stays 0; back to S_IDLE.
2. Simultaneous requests after reset → M0 granted first (o_gnt=01). After M0 ack, M1 is granted (o_gnt=10) with exactly 1 idle cycle between. A third simultaneous round grants M0 again.
3. Retry: slave asserts i_s_rty during an M1 transfer → o_m1_rty=1 that cycle, no ack; next simultaneous request grants M0.
4. Timeout with TIMEOUT=16: slave never acks an M0 read → o_s_cyc held 16 cycles, then dropped for the S_ERR cycle with o_m0_err=1; a late i_s_ack afterwards produces no master ack.
5. Master abort: M1 drops cyc 3 cycles into a transfer → o_s_cyc/stb fall the same cycle; no ack/err to either master; an M0 request is granted next.
6. Async reset asserted mid-transfer (between edges) → all o_s_* and o_m* outputs go to 0 immediately. After release, a pending M1 request is served from S_IDLE with priority reset to M0.

Source files
------------

// File: rtl/flash_wb_arbiter.sv
// flash_wb_arbiter
//   Two-master Wishbone classic arbiter in front of the single flash_controller
//   slave port. One master is granted at a time with round-robin priority. The
//   granted master's cycle is forwarded to the slave; ack/rty/rdt go back only
//   to that master. A watchdog aborts transfers the slave never completes and
//   reports them to the master with err.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_m0_* / o_m0_*      master 0 Wishbone port (adr, dat, sel, we, cyc, stb /
//                        rdt, ack, rty, err)
//   i_m1_* / o_m1_*      master 1 Wishbone port, same as master 0
//   o_s_* / i_s_*        slave port towards flash_controller
//   o_gnt                one-hot current grant, 00 when idle
module flash_wb_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    input  logic [3:0]  i_m0_sel,
    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    output logic        o_m0_rty,
    output logic        o_m0_err,

    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    output logic        o_m1_rty,
    output logic        o_m1_err,

    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack,
    input  logic        i_s_rty,

    output logic [1:0]  o_gnt
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ERR} state_t;

    state_t          state;
    logic            gsel;   // granted master index, meaningful in S_XFER/S_ERR
    logic            ptr;    // master that wins a simultaneous request
    logic [TW-1:0]   wd;

    logic req0, req1, greq;
    logic xfer, err_st, live, ack, rty;

    assign req0 = i_m0_cyc & i_m0_stb;
    assign req1 = i_m1_cyc & i_m1_stb;
    assign greq = gsel ? req1 : req0;

    assign xfer   = (state == S_XFER);
    assign err_st = (state == S_ERR);
    // The slave only sees a cycle while the granted master still holds it.
    assign live   = xfer & greq;
    assign ack    = live & i_s_ack;
    assign rty    = live & i_s_rty & ~i_s_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            gsel  <= 1'b0;
            ptr   <= 1'b0;
            wd    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wd <= '0;
                    if (req0 | req1) begin
                        gsel  <= (req0 & req1) ? ptr : req1;
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!greq) begin
                        // Master abandoned the cycle: no response, priority kept.
                        state <= S_IDLE;
                        wd    <= '0;
                    end else if (i_s_ack | i_s_rty) begin
                        state <= S_IDLE;
                        ptr   <= ~gsel;
                        wd    <= '0;
                    end else if (wd == TW'(TIMEOUT - 1)) begin
                        state <= S_ERR;
                        wd    <= '0;
                    end else if (wd != '1) begin
                        wd <= wd + TW'(1);
                    end
                end
                S_ERR: begin
                    state <= S_IDLE;
                    ptr   <= ~gsel;
                    wd    <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    wd    <= '0;
                end
            endcase
        end
    end

    // Slave-side request mux; forced to zero outside a transfer.
    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        if (xfer) begin
            o_s_adr = gsel ? i_m1_adr : i_m0_adr;
            o_s_dat = gsel ? i_m1_dat : i_m0_dat;
            o_s_sel = gsel ? i_m1_sel : i_m0_sel;
            o_s_we  = gsel ? i_m1_we  : i_m0_we;
        end
    end

    assign o_s_cyc = live;
    assign o_s_stb = live;

    // Responses steered to the granted master only; rdt passes through
    // unregistered and only in the acked cycle.
    assign o_m0_ack = ack & ~gsel;
    assign o_m1_ack = ack &  gsel;
    assign o_m0_rty = rty & ~gsel;
    assign o_m1_rty = rty &  gsel;
    assign o_m0_err = err_st & ~gsel;
    assign o_m1_err = err_st &  gsel;
    assign o_m0_rdt = o_m0_ack ? i_s_rdt : 32'h0;
    assign o_m1_rdt = o_m1_ack ? i_s_rdt : 32'h0;

    assign o_gnt = (xfer | err_st) ? (gsel ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_flash_wb_arbiter.sv
// tb_flash_wb_arbiter
//   Directed bench for flash_wb_arbiter: a table of single transfers (request
//   pattern, slave latency, response, expected grant) followed by hand-written
//   sequences for watchdog timeout, master abort and asynchronous reset.
module tb_flash_wb_arbiter;

    localparam int          TIMEOUT = 16;
    localparam int          TW      = 5;
    localparam logic [31:0] A0      = 32'h1000_0000;
    localparam logic [31:0] A1      = 32'h2000_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [31:0] o_m0_rdt, o_m1_rdt;
    logic        o_m0_ack, o_m0_rty, o_m0_err, o_m1_ack, o_m1_rty, o_m1_err;
    logic [31:0] o_s_adr, o_s_dat;
    logic [3:0]  o_s_sel;
    logic        o_s_we, o_s_cyc, o_s_stb;
    logic [31:0] s_rdt;
    logic        s_ack, s_rty;
    logic [1:0]  o_gnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    flash_wb_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
        .o_m0_rdt(o_m0_rdt), .o_m0_ack(o_m0_ack), .o_m0_rty(o_m0_rty), .o_m0_err(o_m0_err),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
        .o_m1_rdt(o_m1_rdt), .o_m1_ack(o_m1_ack), .o_m1_rty(o_m1_rty), .o_m1_err(o_m1_err),
        .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel), .o_s_we(o_s_we),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack), .i_s_rty(s_rty),
        .o_gnt(o_gnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic req(input logic r0, input logic r1);
        m0_cyc = r0; m0_stb = r0;
        m1_cyc = r1; m1_stb = r1;
    endtask

    typedef struct {
        logic        r0, r1;
        int          lat;
        logic        ack, rty;
        logic [31:0] rdt;
        logic [1:0]  gnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vec_t v;
        int   cnt;
        logic g0;

        // Pointer starts at M0; every ack/rty hands priority to the other master.
        vecs[0] = '{1'b1, 1'b1, 2, 1'b1, 1'b0, 32'h0000_00A1, 2'b01};
        vecs[1] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 32'h0000_00B2, 2'b10};
        vecs[2] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 32'h0000_00C3, 2'b01};
        vecs[3] = '{1'b1, 1'b0, 5, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'b01};
        vecs[4] = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 32'h0000_0055, 2'b10};
        vecs[5] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 32'h0000_1234, 2'b01};
        vecs[6] = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 32'hCAFE_F00D, 2'b10};
        vecs[7] = '{1'b1, 1'b1, 2, 1'b1, 1'b0, 32'h0BAD_0001, 2'b01};

        m0_adr = A0; m0_dat = 32'h1111_1111; m0_sel = 4'hF; m0_we = 1'b0;
        m1_adr = A1; m1_dat = 32'h2222_2222; m1_sel = 4'h3; m1_we = 1'b1;
        s_rdt = 32'h5A5A_5A5A; s_ack = 1'b1; s_rty = 1'b0;
        req(1'b1, 1'b1);
        rst_n = 1'b0;

        // Reset state with active inputs
        #12;
        chk("rst_s_cyc", o_s_cyc, 0);
        chk("rst_s_adr", o_s_adr, 0);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_m0_ack", o_m0_ack, 0);
        chk("rst_m0_rdt", o_m0_rdt, 0);
        chk("rst_m1_ack", o_m1_ack, 0);

        s_ack = 1'b0;
        req(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single transfers; one idle cycle between grants
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            g0 = v.gnt[0];
            req(v.r0, v.r1);
            s_rdt = v.rdt;
            #1;
            chk("idle_gnt", o_gnt, 0);
            chk("idle_s_cyc", o_s_cyc, 0);
            @(negedge clk);
            chk("grant", o_gnt, v.gnt);
            chk("s_cyc_up", o_s_cyc, 1);
            chk("s_adr_mux", o_s_adr, g0 ? A0 : A1);
            repeat (v.lat) @(negedge clk);
            chk("rdt_before_ack", o_m0_rdt | o_m1_rdt, 0);
            s_ack = v.ack;
            s_rty = v.rty;
            #1;
            chk("m0_ack", o_m0_ack, v.ack & g0);
            chk("m1_ack", o_m1_ack, v.ack & ~g0);
            chk("m0_rty", o_m0_rty, v.rty & ~v.ack & g0);
            chk("m1_rty", o_m1_rty, v.rty & ~v.ack & ~g0);
            chk("m0_rdt", o_m0_rdt, (v.ack & g0) ? v.rdt : 32'h0);
            chk("m1_rdt", o_m1_rdt, (v.ack & ~g0) ? v.rdt : 32'h0);
            @(negedge clk);
            s_ack = 1'b0;
            s_rty = 1'b0;
        end
        req(1'b0, 1'b0);
        @(negedge clk);

        // Watchdog: M0 read never acked
        req(1'b1, 1'b0);
        s_rdt = 32'h7777_7777;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_s_cyc) cnt++;
            else break;
        end
        chk("timeout_len", cnt, TIMEOUT);
        chk("timeout_m0_err", o_m0_err, 1);
        chk("timeout_m1_err", o_m1_err, 0);
        chk("timeout_s_stb", o_s_stb, 0);
        chk("timeout_gnt", o_gnt, 2'b01);
        req(1'b0, 1'b0);
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        chk("late_ack_m0", o_m0_ack, 0);
        chk("late_ack_m1", o_m1_ack, 0);
        chk("late_ack_gnt", o_gnt, 0);
        chk("late_ack_m0_err", o_m0_err, 0);
        @(negedge clk);
        s_ack = 1'b0;

        // Master abort: M1 drops cyc mid-transfer
        req(1'b0, 1'b1);
        @(negedge clk);
        chk("abort_gnt", o_gnt, 2'b10);
        repeat (3) @(negedge clk);
        m1_cyc = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        #1;
        chk("abort_s_cyc", o_s_cyc, 0);
        chk("abort_s_stb", o_s_stb, 0);
        chk("abort_m1_ack", o_m1_ack, 0);
        chk("abort_m1_err", o_m1_err, 0);
        @(negedge clk);
        chk("abort_idle", o_gnt, 0);
        chk("abort_no_err", o_m0_err | o_m1_err, 0);
        @(negedge clk);
        chk("abort_next_m0", o_gnt, 2'b01);
        s_rdt = 32'h0000_0ABC;
        s_ack = 1'b1;
        #1;
        chk("abort_m0_ack", o_m0_ack, 1);
        @(negedge clk);
        s_ack = 1'b0;
        req(1'b0, 1'b0);
        @(negedge clk);

        // Async reset mid-transfer; pointer is M1 going in
        req(1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_gnt", o_gnt, 2'b01);
        @(negedge clk);
        s_rdt = 32'h3C3C_3C3C;
        s_ack = 1'b1;
        #1;
        chk("pre_rst_ack", o_m0_ack, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_s_cyc", o_s_cyc, 0);
        chk("arst_s_adr", o_s_adr, 0);
        chk("arst_m0_ack", o_m0_ack, 0);
        chk("arst_m0_rdt", o_m0_rdt, 0);
        chk("arst_gnt", o_gnt, 0);
        s_ack = 1'b0;
        req(1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_prio", o_gnt, 2'b01);
        s_ack = 1'b1;
        #1;
        chk("post_rst_m0_ack", o_m0_ack, 1);
        @(negedge clk);
        s_ack = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        chk("post_rst_idle", o_gnt, 0);
        @(negedge clk);
        chk("post_rst_m1", o_gnt, 2'b10);
        s_ack = 1'b1;
        #1;
        chk("post_rst_m1_ack", o_m1_ack, 1);
        chk("post_rst_m1_rdt", o_m1_rdt, 32'h3C3C_3C3C);
        @(negedge clk);
        s_ack = 1'b0;
        req(1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
